fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle-read instruction memory (combinational word read, address >> 2). Owns the PC and drives the memory address. Registers each fetched word into an IF/ID holding stage. Handles stall, branch and jump redirects from decode, and halts when the PC leaves the populated memory range.

Parameters:
RESET_PC, 32'd40, byte address loaded into PC on reset (word 10, first program word)
MEM_WORDS, 250, number of instruction words; fetch limit = MEM_WORDS*4 bytes

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high reset
imem_addr  output  32  byte address to instruction memory; equals PC register
imem_instr  input  32  instruction word returned combinationally for imem_addr
stall  input  1  decode not ready; hold PC and IF/ID contents
branch_taken  input  1  decode resolved taken branch for instruction in IF/ID
branch_offset  input  16  branch immediate (word offset, signed)
jump  input  1  decode resolved J-type for instruction in IF/ID
jump_target  input  26  J-type target field
if_instr  output  32  registered instruction to decode
if_pc  output  32  byte address of if_instr
if_pc4  output  32  if_pc + 4
if_valid  output  1  if_instr is a real fetched instruction
halted  output  1  fetch stopped; PC out of range

Behaviour:
- Reset (reset=1 at clk edge, any state, mid-fetch included):
  - pc=RESET_PC; state=BOOT
  - if_instr=0, if_pc=0, if_pc4=0, if_valid=0, halted=0
- imem_addr = pc at all times (combinational from the register).
- States: BOOT, FETCH, HALT. Encoding is free.
- BOOT: one cycle. No capture; if_valid stays 0. Next state: FETCH.
- FETCH, priority per cycle, highest first:
  1. stall=1: pc, if_* and state all hold. Redirect inputs are ignored; decode re-presents them after the stall.
  2. if_valid=1 and jump=1: pc<={if_pc4[31:28], jump_target, 2'b00}; if_valid<=0; if_instr<=0. The wrong-path word is discarded, giving one bubble. Jump wins over branch when both are asserted.
  3. if_valid=1 and branch_taken=1: pc<=if_pc4 + (sign_extend(branch_offset)<<2), mod 2^32; if_valid<=0; if_instr<=0. One bubble.
  4. pc >= MEM_WORDS*4 (unsigned): state<=HALT; halted<=1; if_valid<=0. The out-of-range word is never captured.
  5. Otherwise: if_instr<=imem_instr; if_pc<=pc; if_pc4<=pc+4; if_valid<=1; pc<=pc+4 (32-bit wrap).
- A redirect target that is out of range is accepted into pc. HALT follows on the next FETCH cycle per rule 4.
- HALT: pc, if_instr, if_pc and if_pc4 frozen; if_valid=0; halted=1. stall, jump and branch are ignored. Only reset exits HALT.
- Latency: instruction at address A appears on if_instr one clock after pc=A with no stall. Steady state is one instruction per clock. A redirect costs exactly one bubble cycle.
- branch_taken and jump are ignored when if_valid=0 (bubble or BOOT).

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds two ports.
  - fetch_count, output, 32: increments on every rule-5 capture.
  - stall_count, output, 32: increments on every FETCH cycle with stall=1.
  - Both clear to 0 on reset, wrap at 2^32, and freeze in HALT.
- Undefined: neither port nor counter logic exists; all other behaviour is identical.

Test Plan:
- Reset release, memory words 10..12 = addi encodings:
  - imem_addr=40 during BOOT and if_valid=0.
  - On the next edge: if_pc=40, if_pc4=44, if_instr=mem[10], if_valid=1.
  - Then if_pc=44, then 48, one per clock.
- Jump: with if_pc=52, jump=1, jump_target=26'd8:
  - Next cycle pc/imem_addr=32, if_valid=0.
  - Following cycle if_pc=32, if_instr=mem[8].
- Branch: with if_pc=52, branch_taken=1, branch_offset=16'hFFFE:
  - pc=48 and one bubble.
  - Then if_pc=48. With jump and branch_taken both high, the jump target is used.
- Stall=1 for 3 cycles while if_pc=44:
  - imem_addr=48 and if_pc=44 held, if_valid=1 held.
  - A jump asserted during the stall has no effect.
  - Sequential fetch resumes at 48 after the stall.
- Range end, RESET_PC=992, MEM_WORDS=250:
  - Fetches 992 and 996.
  - Next cycle halted=1 and if_valid=0, with if_pc=996 frozen.
  - Later stall/jump pulses leave all outputs unchanged.
- Reset asserted mid-run (if_pc=48) and while HALT:
  - Next edge gives pc=40, if_valid=0, halted=0, state BOOT.
  - With FETCH_PERF_CNT_EN: fetch_count=3 and stall_count=3 before reset, both 0 after.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, fills the IF/ID stage, applies decode redirects and
// halts past the end of instruction memory. Define FETCH_PERF_CNT_EN to add perf counters.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'd40,
    parameter int unsigned MEM_WORDS = 250
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_offset,
    input  logic        jump,
    input  logic [25:0] jump_target,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc4,
    output logic        if_valid,
    output logic        halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    localparam logic [31:0] PcLimit = 32'(MEM_WORDS * 4);

    typedef enum logic [1:0] {
        StBoot,
        StFetch,
        StHalt
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_pc4_q, if_pc4_d;
    logic        if_valid_q, if_valid_d;

    logic [31:0] jump_pc;
    logic [31:0] branch_pc;

    // Redirect targets are relative to the instruction sitting in IF/ID, not to the live PC.
    assign jump_pc   = {if_pc4_q[31:28], jump_target, 2'b00};
    assign branch_pc = if_pc4_q + {{14{branch_offset[15]}}, branch_offset, 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;
        if_pc4_d   = if_pc4_q;
        if_valid_d = if_valid_q;

        case (state_q)
            StBoot: begin
                if_valid_d = 1'b0;
                state_d    = StFetch;
            end
            StFetch: begin
                if (stall) begin
                    // Hold everything; decode re-presents any redirect afterwards.
                end else if (if_valid_q && jump) begin
                    pc_d       = jump_pc;
                    if_valid_d = 1'b0;
                    if_instr_d = '0;
                end else if (if_valid_q && branch_taken) begin
                    pc_d       = branch_pc;
                    if_valid_d = 1'b0;
                    if_instr_d = '0;
                end else if (pc_q >= PcLimit) begin
                    state_d    = StHalt;
                    if_valid_d = 1'b0;
                end else begin
                    if_instr_d = imem_instr;
                    if_pc_d    = pc_q;
                    if_pc4_d   = pc_q + 32'd4;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + 32'd4;
                end
            end
            StHalt: begin
                if_valid_d = 1'b0;
            end
            default: begin
                state_d = StBoot;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StBoot;
            pc_q       <= RESET_PC;
            if_instr_q <= '0;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            if_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
            if_pc4_q   <= if_pc4_d;
            if_valid_q <= if_valid_d;
        end
    end

    assign imem_addr = pc_q;
    assign if_instr  = if_instr_q;
    assign if_pc     = if_pc_q;
    assign if_pc4    = if_pc4_q;
    assign if_valid  = if_valid_q;
    assign halted    = (state_q == StHalt);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        fetch_capture;
    logic        fetch_stall;

    // Only a fresh capture can raise if_valid_d while fetching unstalled.
    assign fetch_capture = (state_q == StFetch) && !stall && if_valid_d;
    assign fetch_stall   = (state_q == StFetch) && stall;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_capture) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if (fetch_stall) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign fetch_count = fetch_cnt_q;
    assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected IF/ID addresses, a monitor checks
// every fresh capture. A second instance starts near the end of memory to exercise HALT.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset, reset2;
    logic        stall, stall2;
    logic        branch_taken, branch_taken2;
    logic        jump, jump2;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;

    logic [31:0] imem_addr, imem_instr, if_instr, if_pc, if_pc4;
    logic        if_valid, halted;
    logic [31:0] imem_addr2, imem_instr2, if_instr2, if_pc2, if_pc42;
    logic        if_valid2, halted2;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fc1, sc1, fc2, sc2;
`endif

    int checks;
    int failures;

    logic [31:0] exp_q[$];
    logic [31:0] exp2_q[$];
    logic        stall_seen, stall2_seen;
    logic [31:0] e1, e2;

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        if (w >= 30'd250) return 32'hFFFF_FFFF;
        return 32'h2008_0000 | {2'b00, w};
    endfunction

    assign imem_instr  = mem_word(imem_addr[31:2]);
    assign imem_instr2 = mem_word(imem_addr2[31:2]);

    fetch_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .imem_addr    (imem_addr),
        .imem_instr   (imem_instr),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .if_instr     (if_instr),
        .if_pc        (if_pc),
        .if_pc4       (if_pc4),
        .if_valid     (if_valid),
        .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fc1),
        .stall_count  (sc1)
`endif
    );

    fetch_ctrl #(
        .RESET_PC (32'd992),
        .MEM_WORDS(250)
    ) dut_end (
        .clk          (clk),
        .reset        (reset2),
        .imem_addr    (imem_addr2),
        .imem_instr   (imem_instr2),
        .stall        (stall2),
        .branch_taken (branch_taken2),
        .branch_offset(branch_offset),
        .jump         (jump2),
        .jump_target  (jump_target),
        .if_instr     (if_instr2),
        .if_pc        (if_pc2),
        .if_pc4       (if_pc42),
        .if_valid     (if_valid2),
        .halted       (halted2)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_count  (fc2),
        .stall_count  (sc2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%08h) required=%0d (0x%08h) t=%0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // A capture is fresh when the edge that produced it was not a stall edge.
    always @(posedge clk) begin
        stall_seen  <= stall;
        stall2_seen <= stall2;
    end

    always @(negedge clk) begin
        if (if_valid && !stall_seen) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_pc", if_pc, 32'hFFFF_FFFF);
            end else begin
                e1 = exp_q.pop_front();
                chk("sb_pc", if_pc, e1);
                chk("sb_pc4", if_pc4, e1 + 32'd4);
                chk("sb_instr", if_instr, mem_word(e1[31:2]));
            end
        end
        if (if_valid2 && !stall2_seen) begin
            if (exp2_q.size() == 0) begin
                chk("sb2_unexpected_pc", if_pc2, 32'hFFFF_FFFF);
            end else begin
                e2 = exp2_q.pop_front();
                chk("sb2_pc", if_pc2, e2);
                chk("sb2_pc4", if_pc42, e2 + 32'd4);
                chk("sb2_instr", if_instr2, mem_word(e2[31:2]));
            end
        end
    end

    task automatic chk_halt2();
        chk("end_halted", 32'(halted2), 32'd1);
        chk("end_valid", 32'(if_valid2), 32'd0);
        chk("end_pc", if_pc2, 32'd996);
        chk("end_pc4", if_pc42, 32'd1000);
        chk("end_instr", if_instr2, mem_word(30'd249));
        chk("end_addr", imem_addr2, 32'd1000);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        reset2 = 1'b1;
        stall = 1'b0;
        stall2 = 1'b0;
        branch_taken = 1'b0;
        branch_taken2 = 1'b0;
        jump = 1'b0;
        jump2 = 1'b0;
        branch_offset = '0;
        jump_target = '0;
        step();
        step();
        chk("rst_addr", imem_addr, 32'd40);
        chk("rst_valid", 32'(if_valid), 32'd0);
        chk("rst_instr", if_instr, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_pc4", if_pc4, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);

        // Range end on the second instance; the first stays in reset.
        reset2 = 1'b0;
        step();
        chk("end_boot_addr", imem_addr2, 32'd992);
        chk("end_boot_valid", 32'(if_valid2), 32'd0);
        exp2_q.push_back(32'd992);
        exp2_q.push_back(32'd996);
        step();
        step();
        step();
        chk_halt2();
        stall2 = 1'b1;
        jump2 = 1'b1;
        branch_taken2 = 1'b1;
        jump_target = 26'd8;
        branch_offset = 16'hFFFE;
        step();
        stall2 = 1'b0;
        step();
        jump2 = 1'b0;
        branch_taken2 = 1'b0;
        step();
        chk_halt2();
`ifdef FETCH_PERF_CNT_EN
        chk("end_fetch_count", fc2, 32'd2);
        chk("end_stall_count", sc2, 32'd0);
`endif

        // Boot and sequential fetch, then a 3-cycle stall with a jump that must be ignored.
        reset = 1'b0;
        step();
        chk("boot_addr", imem_addr, 32'd40);
        chk("boot_valid", 32'(if_valid), 32'd0);
        exp_q.push_back(32'd40);
        exp_q.push_back(32'd44);
        step();
        step();
        stall = 1'b1;
        jump = 1'b1;
        jump_target = 26'd8;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr", imem_addr, 32'd48);
            chk("stall_pc", if_pc, 32'd44);
            chk("stall_valid", 32'(if_valid), 32'd1);
        end
        stall = 1'b0;
        jump = 1'b0;
        exp_q.push_back(32'd48);
        step();
        chk("resume_addr", imem_addr, 32'd52);
`ifdef FETCH_PERF_CNT_EN
        chk("mid_fetch_count", fc1, 32'd3);
        chk("mid_stall_count", sc1, 32'd3);
`endif
        reset = 1'b1;
        step();
        chk("midrst_addr", imem_addr, 32'd40);
        chk("midrst_valid", 32'(if_valid), 32'd0);
        chk("midrst_halted", 32'(halted), 32'd0);
`ifdef FETCH_PERF_CNT_EN
        chk("midrst_fetch_count", fc1, 32'd0);
        chk("midrst_stall_count", sc1, 32'd0);
`endif
        reset = 1'b0;
        step();
        chk("boot2_valid", 32'(if_valid), 32'd0);

        // Jump from if_pc=52 to word 8.
        exp_q.push_back(32'd40);
        exp_q.push_back(32'd44);
        exp_q.push_back(32'd48);
        exp_q.push_back(32'd52);
        repeat (4) step();
        jump = 1'b1;
        jump_target = 26'd8;
        step();
        jump = 1'b0;
        chk("jmp_addr", imem_addr, 32'd32);
        chk("jmp_valid", 32'(if_valid), 32'd0);
        chk("jmp_instr", if_instr, 32'd0);

        // Backward branch from if_pc=52: 56 - 8 = 48.
        exp_q.push_back(32'd32);
        exp_q.push_back(32'd36);
        exp_q.push_back(32'd40);
        exp_q.push_back(32'd44);
        exp_q.push_back(32'd48);
        exp_q.push_back(32'd52);
        repeat (6) step();
        branch_taken = 1'b1;
        branch_offset = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        chk("br_addr", imem_addr, 32'd48);
        chk("br_valid", 32'(if_valid), 32'd0);

        // Jump beats branch; jump held into the bubble must be ignored.
        exp_q.push_back(32'd48);
        exp_q.push_back(32'd52);
        repeat (2) step();
        jump = 1'b1;
        jump_target = 26'd5;
        branch_taken = 1'b1;
        branch_offset = 16'hFFFE;
        step();
        branch_taken = 1'b0;
        chk("both_addr", imem_addr, 32'd20);
        chk("both_valid", 32'(if_valid), 32'd0);
        exp_q.push_back(32'd20);
        step();
        jump = 1'b0;
        chk("bubble_ign_addr", imem_addr, 32'd24);

        // Forward branch from if_pc=24: 28 + 12 = 40.
        exp_q.push_back(32'd24);
        step();
        branch_taken = 1'b1;
        branch_offset = 16'h0003;
        step();
        branch_taken = 1'b0;
        chk("fwd_addr", imem_addr, 32'd40);

        // Out-of-range jump target is accepted, then HALT on the next fetch cycle.
        exp_q.push_back(32'd40);
        step();
        jump = 1'b1;
        jump_target = 26'd300;
        step();
        jump = 1'b0;
        chk("oor_addr", imem_addr, 32'd1200);
        chk("oor_valid", 32'(if_valid), 32'd0);
        chk("oor_halted", 32'(halted), 32'd0);
        step();
        chk("hlt_halted", 32'(halted), 32'd1);
        chk("hlt_valid", 32'(if_valid), 32'd0);
        chk("hlt_pc", if_pc, 32'd40);
        chk("hlt_addr", imem_addr, 32'd1200);
        stall = 1'b1;
        jump = 1'b1;
        jump_target = 26'd8;
        step();
        stall = 1'b0;
        step();
        jump = 1'b0;
        step();
        chk("hlt2_halted", 32'(halted), 32'd1);
        chk("hlt2_valid", 32'(if_valid), 32'd0);
        chk("hlt2_pc", if_pc, 32'd40);
        chk("hlt2_pc4", if_pc4, 32'd44);
        chk("hlt2_instr", if_instr, 32'd0);
        chk("hlt2_addr", imem_addr, 32'd1200);

        reset = 1'b1;
        step();
        chk("hltrst_addr", imem_addr, 32'd40);
        chk("hltrst_halted", 32'(halted), 32'd0);
        chk("hltrst_valid", 32'(if_valid), 32'd0);
        step();

        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        chk("sb2_drain", 32'(exp2_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
